// File: rtl/bulls_cows_game_ctrl_pkg.sv
// Shared definitions for the Bulls & Cows game controller and its display stage:
// state codes, digit/secret widths and a digit extraction helper.
package bulls_cows_game_ctrl_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SECRET_W   = DIGIT_W * NUM_DIGITS;
  localparam int unsigned COUNT_W    = 3;
  localparam int unsigned POINT_W    = 8;

  localparam logic [COUNT_W-1:0] ALL_BULLS = COUNT_W'(NUM_DIGITS);

  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } state_t;

  // Position 0 is the most significant digit.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [SECRET_W-1:0] v,
                                                  input int unsigned pos);
    return v[SECRET_W-1-pos*DIGIT_W -: DIGIT_W];
  endfunction

endpackage

// File: rtl/bulls_cows_game_ctrl_scorer.sv
// Combinational scorer: bulls, cows and guess-validity for one guess/secret pair.
// DIGIT_VALIDATION_EN: when defined, valid requires four distinct digits 0..9;
// otherwise valid is constantly 1.
module bulls_cows_scorer
  import bulls_cows_game_ctrl_pkg::*;
(
  input  logic [SECRET_W-1:0] guess,
  input  logic [SECRET_W-1:0] secret,
  output logic [COUNT_W-1:0]  bulls,
  output logic [COUNT_W-1:0]  cows,
  output logic                valid
);

  logic [NUM_DIGITS-1:0] hit;
  logic                  cow_hit;

  // Per-position exact matches.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      hit[i] = (digit_at(guess, i) == digit_at(secret, i));
  end

  // Count bulls; a non-bull position is a cow if its digit appears at another non-bull secret position.
  always_comb begin
    bulls   = '0;
    cows    = '0;
    cow_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (hit[i]) begin
        bulls = bulls + 1'b1;
      end else begin
        cow_hit = 1'b0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++)
          if (j != i && !hit[j] && digit_at(guess, i) == digit_at(secret, j))
            cow_hit = 1'b1;
        if (cow_hit)
          cows = cows + 1'b1;
      end
    end
  end

`ifdef DIGIT_VALIDATION_EN
  // Digits must be decimal and pairwise distinct.
  always_comb begin
    valid = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_at(guess, i) > DIGIT_W'(9))
        valid = 1'b0;
      for (int unsigned j = i + 1; j < NUM_DIGITS; j++)
        if (digit_at(guess, i) == digit_at(guess, j))
          valid = 1'b0;
    end
  end
`else
  assign valid = 1'b1;
`endif

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Two-player Bulls & Cows game controller: secret setup, alternating scored
// guesses, win detection and saturating per-player point counters.
// Optional macro DIGIT_VALIDATION_EN rejects setup/guess events whose digits
// are not four distinct values 0..9.
module bulls_cows_game_ctrl
  import bulls_cows_game_ctrl_pkg::*;
#(
  parameter logic [POINT_W-1:0] POINT_MAX = 8'd255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                confirm,
  input  logic [SECRET_W-1:0] SW,
  output logic [2:0]          game_state,
  output logic                J1_guess_confirmed,
  output logic                J2_guess_confirmed,
  output logic [COUNT_W-1:0]  J1_bull_count,
  output logic [COUNT_W-1:0]  J1_cow_count,
  output logic [COUNT_W-1:0]  J2_bull_count,
  output logic [COUNT_W-1:0]  J2_cow_count,
  output logic [POINT_W-1:0]  J1_points,
  output logic [POINT_W-1:0]  J2_points
);

  state_t                state_q, state_d;
  logic                  confirm_q;
  logic                  armed_q;
  logic                  evt;
  logic [SECRET_W-1:0]   secret1_q, secret1_d, secret2_q, secret2_d;
  logic [SECRET_W-1:0]   secret_sel;
  logic [COUNT_W-1:0]    bulls, cows;
  logic                  score_valid;
  logic                  j1_flag_d, j2_flag_d;
  logic [COUNT_W-1:0]    j1_b_d, j1_c_d, j2_b_d, j2_c_d;
  logic [POINT_W-1:0]    j1_pts_d, j2_pts_d;

  // armed_q suppresses the first cycle after reset so a level held through
  // reset release is captured into confirm_q instead of counting as a press.
  assign evt        = armed_q && confirm && !confirm_q;
  assign secret_sel = (state_q == J2_GUESS) ? secret1_q : secret2_q;
  assign game_state = state_q;

  bulls_cows_scorer u_scorer (
    .guess  (SW),
    .secret (secret_sel),
    .bulls  (bulls),
    .cows   (cows),
    .valid  (score_valid)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= J1_SETUP;
      confirm_q          <= 1'b0;
      armed_q            <= 1'b0;
      secret1_q          <= '0;
      secret2_q          <= '0;
      J1_guess_confirmed <= 1'b0;
      J2_guess_confirmed <= 1'b0;
      J1_bull_count      <= '0;
      J1_cow_count       <= '0;
      J2_bull_count      <= '0;
      J2_cow_count       <= '0;
      J1_points          <= '0;
      J2_points          <= '0;
    end else begin
      state_q            <= state_d;
      confirm_q          <= confirm;
      armed_q            <= 1'b1;
      secret1_q          <= secret1_d;
      secret2_q          <= secret2_d;
      J1_guess_confirmed <= j1_flag_d;
      J2_guess_confirmed <= j2_flag_d;
      J1_bull_count      <= j1_b_d;
      J1_cow_count       <= j1_c_d;
      J2_bull_count      <= j2_b_d;
      J2_cow_count       <= j2_c_d;
      J1_points          <= j1_pts_d;
      J2_points          <= j2_pts_d;
    end
  end

  // Next-state selection; unknown codes fall back to J1_SETUP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      J1_SETUP: if (evt && score_valid) state_d = J2_SETUP;
      J2_SETUP: if (evt && score_valid) state_d = J1_GUESS;
      J1_GUESS:
        if (evt) begin
          if (J1_guess_confirmed)                       state_d = J2_GUESS;
          else if (score_valid && bulls == ALL_BULLS)   state_d = END_GAME;
        end
      J2_GUESS:
        if (evt) begin
          if (J2_guess_confirmed)                       state_d = J1_GUESS;
          else if (score_valid && bulls == ALL_BULLS)   state_d = END_GAME;
        end
      END_GAME: if (evt) state_d = J1_SETUP;
      default:  state_d = J1_SETUP;
    endcase
  end

  // Next values of secrets, scores, flags and points.
  always_comb begin
    secret1_d = secret1_q;
    secret2_d = secret2_q;
    j1_flag_d = J1_guess_confirmed;
    j2_flag_d = J2_guess_confirmed;
    j1_b_d    = J1_bull_count;
    j1_c_d    = J1_cow_count;
    j2_b_d    = J2_bull_count;
    j2_c_d    = J2_cow_count;
    j1_pts_d  = J1_points;
    j2_pts_d  = J2_points;
    case (state_q)
      J1_SETUP: if (evt && score_valid) secret1_d = SW;
      J2_SETUP: if (evt && score_valid) secret2_d = SW;
      J1_GUESS:
        if (evt) begin
          if (J1_guess_confirmed) begin
            j1_flag_d = 1'b0;
          end else if (score_valid) begin
            if (bulls == ALL_BULLS) begin
              j1_pts_d = (J1_points < POINT_MAX) ? J1_points + 1'b1 : POINT_MAX;
              j1_b_d   = ALL_BULLS;
              j1_c_d   = '0;
            end else begin
              j1_b_d    = bulls;
              j1_c_d    = cows;
              j1_flag_d = 1'b1;
            end
          end
        end
      J2_GUESS:
        if (evt) begin
          if (J2_guess_confirmed) begin
            j2_flag_d = 1'b0;
          end else if (score_valid) begin
            if (bulls == ALL_BULLS) begin
              j2_pts_d = (J2_points < POINT_MAX) ? J2_points + 1'b1 : POINT_MAX;
              j2_b_d   = ALL_BULLS;
              j2_c_d   = '0;
            end else begin
              j2_b_d    = bulls;
              j2_c_d    = cows;
              j2_flag_d = 1'b1;
            end
          end
        end
      END_GAME:
        if (evt) begin
          j1_flag_d = 1'b0;
          j2_flag_d = 1'b0;
          j1_b_d    = '0;
          j1_c_d    = '0;
          j2_b_d    = '0;
          j2_c_d    = '0;
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Self-checking bench for bulls_cows_game_ctrl: directed table, corner-case
// sequences and randomized play against a game-level reference model.
module tb_bulls_cows_game_ctrl;

`ifdef DIGIT_VALIDATION_EN
  localparam bit VALIDATE = 1'b1;
`else
  localparam bit VALIDATE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        confirm = 1'b0;
  logic [15:0] SW = '0;
  logic [2:0]  game_state;
  logic        J1_guess_confirmed, J2_guess_confirmed;
  logic [2:0]  J1_bull_count, J1_cow_count, J2_bull_count, J2_cow_count;
  logic [7:0]  J1_points, J2_points;

  always #5 clock = ~clock;

  bulls_cows_game_ctrl #(.POINT_MAX(8'd255)) dut (
    .clock              (clock),
    .reset              (reset),
    .confirm            (confirm),
    .SW                 (SW),
    .game_state         (game_state),
    .J1_guess_confirmed (J1_guess_confirmed),
    .J2_guess_confirmed (J2_guess_confirmed),
    .J1_bull_count      (J1_bull_count),
    .J1_cow_count       (J1_cow_count),
    .J2_bull_count      (J2_bull_count),
    .J2_cow_count       (J2_cow_count),
    .J1_points          (J1_points),
    .J2_points          (J2_points)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (game-level view).
  int          m_state;
  logic [15:0] m_sec1, m_sec2;
  int          m_b1, m_c1, m_f1, m_b2, m_c2, m_f2, m_p1, m_p2;

  typedef struct {
    logic [15:0] sw;
    int st, b1, c1, f1, b2, c2, f2, p1, p2;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dig(input logic [15:0] v, input int p);
    logic [3:0] d;
    d = v[15-4*p -: 4];
    return int'(d);
  endfunction

  function automatic bit digits_ok(input logic [15:0] v);
    bit ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (dig(v, i) > 9) ok = 0;
      for (int j = 0; j < 4; j++)
        if (i != j && dig(v, i) == dig(v, j)) ok = 0;
    end
    return ok;
  endfunction

  function automatic bit accepted(input logic [15:0] v);
    return !VALIDATE || digits_ok(v);
  endfunction

  task automatic score(input logic [15:0] g, input logic [15:0] s, output int b, output int c);
    bit hit[4];
    b = 0; c = 0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = (dig(g, i) == dig(s, i));
      if (hit[i]) b++;
    end
    for (int i = 0; i < 4; i++) begin
      bit found = 0;
      if (!hit[i])
        for (int j = 0; j < 4; j++)
          if (j != i && !hit[j] && dig(g, i) == dig(s, j)) found = 1;
      if (found) c++;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sec1 = '0; m_sec2 = '0;
    m_b1 = 0; m_c1 = 0; m_f1 = 0; m_b2 = 0; m_c2 = 0; m_f2 = 0; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_event(input logic [15:0] sw);
    int b, c;
    case (m_state)
      0: if (accepted(sw)) begin m_sec1 = sw; m_state = 1; end
      1: if (accepted(sw)) begin m_sec2 = sw; m_state = 2; end
      2: if (m_f1 == 1) begin m_f1 = 0; m_state = 3; end
         else if (accepted(sw)) begin
           score(sw, m_sec2, b, c);
           if (b == 4) begin m_p1 = (m_p1 < 255) ? m_p1 + 1 : 255; m_b1 = 4; m_c1 = 0; m_state = 7; end
           else begin m_b1 = b; m_c1 = c; m_f1 = 1; end
         end
      3: if (m_f2 == 1) begin m_f2 = 0; m_state = 2; end
         else if (accepted(sw)) begin
           score(sw, m_sec1, b, c);
           if (b == 4) begin m_p2 = (m_p2 < 255) ? m_p2 + 1 : 255; m_b2 = 4; m_c2 = 0; m_state = 7; end
           else begin m_b2 = b; m_c2 = c; m_f2 = 1; end
         end
      default: begin m_b1 = 0; m_c1 = 0; m_f1 = 0; m_b2 = 0; m_c2 = 0; m_f2 = 0; m_state = 0; end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, game_state, m_state);
    check({tag, ".j1_flag"}, J1_guess_confirmed, m_f1);
    check({tag, ".j2_flag"}, J2_guess_confirmed, m_f2);
    check({tag, ".j1_bulls"}, J1_bull_count, m_b1);
    check({tag, ".j1_cows"}, J1_cow_count, m_c1);
    check({tag, ".j2_bulls"}, J2_bull_count, m_b2);
    check({tag, ".j2_cows"}, J2_cow_count, m_c2);
    check({tag, ".j1_pts"}, J1_points, m_p1);
    check({tag, ".j2_pts"}, J2_points, m_p2);
  endtask

  // One press: confirm high for 'hold' rising edges, outputs checked while still held.
  task automatic press(input logic [15:0] sw, input int hold, input string tag);
    @(negedge clock);
    SW = sw;
    confirm = 1'b1;
    repeat (hold) @(negedge clock);
    model_event(sw);
    check_all(tag);
    confirm = 1'b0;
  endtask

  task automatic do_reset(input logic conf_level);
    @(negedge clock);
    reset = 1'b0;
    confirm = conf_level;
    @(negedge clock);
    model_reset();
    check_all("reset");
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] sw;
    tbl[0] = '{16'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{16'h5678, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{16'h5687, 2, 2, 2, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{16'h0000, 3, 2, 2, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{16'h1234, 7, 2, 2, 0, 4, 0, 0, 0, 1};
    tbl[5] = '{16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    // Directed game: setup, scored guess, acknowledge, win, restart.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      press(tbl[i].sw, 1, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.st", i), game_state, tbl[i].st);
      check($sformatf("tbl%0d.b1", i), J1_bull_count, tbl[i].b1);
      check($sformatf("tbl%0d.c1", i), J1_cow_count, tbl[i].c1);
      check($sformatf("tbl%0d.f1", i), J1_guess_confirmed, tbl[i].f1);
      check($sformatf("tbl%0d.b2", i), J2_bull_count, tbl[i].b2);
      check($sformatf("tbl%0d.c2", i), J2_cow_count, tbl[i].c2);
      check($sformatf("tbl%0d.f2", i), J2_guess_confirmed, tbl[i].f2);
      check($sformatf("tbl%0d.p1", i), J1_points, tbl[i].p1);
      check($sformatf("tbl%0d.p2", i), J2_points, tbl[i].p2);
    end

    // Digit validation on setup events.
    do_reset(1'b0);
    press(16'h1123, 1, "val_dup");
    check("val_dup.st", game_state, VALIDATE ? 0 : 1);
    do_reset(1'b0);
    press(16'h12A4, 1, "val_hex");
    check("val_hex.st", game_state, VALIDATE ? 0 : 1);

    // Confirm held for 10 cycles counts once.
    do_reset(1'b0);
    press(16'h1234, 10, "held");
    check("held.st", game_state, 1);
    repeat (2) @(negedge clock);
    check("held_after.st", game_state, 1);

    // Confirm high through reset release is not an event.
    do_reset(1'b1);
    repeat (3) @(negedge clock);
    check_all("hold_thru_reset");
    check("hold_thru_reset.st", game_state, 0);
    confirm = 1'b0;

    // Mid-round reset in J2_GUESS with scored results present.
    do_reset(1'b0);
    press(16'h1234, 1, "mid_s1");
    press(16'h5678, 1, "mid_s2");
    press(16'h5687, 1, "mid_g1");
    press(16'h0000, 1, "mid_ack");
    press(16'h2143, 1, "mid_g2");
    check("mid.st", game_state, 3);
    do_reset(1'b0);
    check("mid_rst.st", game_state, 0);
    check("mid_rst.j2b", J2_bull_count, 0);

    // Point saturation after 256 J1 wins.
    for (int k = 0; k < 256; k++) begin
      press(16'h1234, 1, "sat_s1");
      press(16'h5678, 1, "sat_s2");
      press(16'h5678, 1, "sat_win");
      press(16'h0000, 1, "sat_end");
    end
    check("sat.j1_pts", J1_points, 255);

    // Randomized play against the reference model.
    do_reset(1'b0);
    for (int k = 0; k < 400; k++) begin
      int r = $urandom_range(0, 99);
      if (r < 25 && m_state == 2)      sw = m_sec2;
      else if (r < 25 && m_state == 3) sw = m_sec1;
      else if (r < 40)                 sw = 16'($urandom);
      else begin
        for (int d = 0; d < 4; d++) sw[15-4*d -: 4] = 4'($urandom_range(0, 9));
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      press(sw, $urandom_range(1, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
